// File: rtl/sd_pkg.sv
// Shared constants for the SD sector path: op codes, address width and the
// sequencer state encoding, which debug tooling decodes alongside the controller's.
package sd_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int SECTOR_ADDR_W = 26;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_XFER   = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;

  // Tie goes to the port that did not win last; otherwise the lone requester.
  function automatic logic rr_pick(input logic valid0, input logic valid1, input logic last_grant);
    return (valid0 && valid1) ? ~last_grant : valid1;
  endfunction

endpackage

// File: rtl/sd_rr_arbiter.sv
// Two-input round-robin grant. last_grant only moves when a sector retires,
// so a port keeps its turn across the whole launch/transfer sequence.
module sd_rr_arbiter
  import sd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic retire,
  input  logic retire_port,
  output logic grant_valid,
  output logic grant
);

  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (retire) begin
      last_grant <= retire_port;
    end
  end

  assign grant_valid = valid0 | valid1;
  assign grant       = rr_pick(valid0, valid1, last_grant);

endmodule

// File: rtl/sd_sector_arbiter.sv
// Arbitrates two sector requesters onto one SD sector controller, sequences the
// execute/busy handshake, steers byte data and reports done/error per sector.
module sd_sector_arbiter
  import sd_pkg::*;
#(
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic                     req0_op,
  input  logic [SECTOR_ADDR_W-1:0] req0_addr,
  input  logic [7:0]               req0_wdata,
  output logic                     req0_ready,
  output logic                     req0_byte_stb,
  output logic                     req0_done,
  output logic                     req0_error,
  input  logic                     req1_valid,
  input  logic                     req1_op,
  input  logic [SECTOR_ADDR_W-1:0] req1_addr,
  input  logic [7:0]               req1_wdata,
  output logic                     req1_ready,
  output logic                     req1_byte_stb,
  output logic                     req1_done,
  output logic                     req1_error,
  output logic [7:0]               rdata,
  output logic                     sd_execute,
  output logic                     sd_op_code,
  output logic [SECTOR_ADDR_W-1:0] sd_sector_address,
  output logic [7:0]               sd_outgoing_byte,
  input  logic [7:0]               sd_incoming_byte,
  input  logic                     sd_finished_byte,
  input  logic                     sd_finished_sector,
  input  logic                     sd_busy
);

  localparam int CNT_W = $clog2(SECTOR_BYTES) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic             gnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [TMR_W-1:0] timer;
  logic             timer_hit;
  logic             arb_valid;
  logic             arb_grant;
  logic             retire;
  logic             byte_evt;
  logic             finish_evt;
  logic             abort_evt;

  assign retire    = (state == ST_FINISH) || (state == ST_ABORT);
  assign cnt_next  = byte_cnt + 1'b1;
  assign timer_hit = (timer == TMR_LAST);

  sd_rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .retire      (retire),
    .retire_port (gnt),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // Write data is only driven while a sector is in flight, so the bus idles at 0.
  assign sd_outgoing_byte = ((state == ST_LAUNCH) || (state == ST_XFER)) ?
                            (gnt ? req1_wdata : req0_wdata) : 8'h00;

  // A byte arriving with the sector strobe is counted before the length check.
  always_comb begin
    byte_evt   = 1'b0;
    finish_evt = 1'b0;
    abort_evt  = 1'b0;
    case (state)
      ST_LAUNCH: abort_evt = timer_hit;
      ST_XFER: begin
        if (sd_finished_byte && (byte_cnt == CNT_FULL)) begin
          abort_evt = 1'b1;
        end else if (sd_finished_byte) begin
          byte_evt = 1'b1;
          if (sd_finished_sector) begin
            finish_evt = (cnt_next == CNT_FULL);
            abort_evt  = (cnt_next != CNT_FULL);
          end
        end else if (sd_finished_sector) begin
          finish_evt = (byte_cnt == CNT_FULL);
          abort_evt  = (byte_cnt != CNT_FULL);
        end else begin
          abort_evt = timer_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      gnt               <= 1'b0;
      byte_cnt          <= '0;
      timer             <= '0;
      req0_ready        <= 1'b0;
      req1_ready        <= 1'b0;
      req0_byte_stb     <= 1'b0;
      req1_byte_stb     <= 1'b0;
      req0_done         <= 1'b0;
      req1_done         <= 1'b0;
      req0_error        <= 1'b0;
      req1_error        <= 1'b0;
      rdata             <= 8'h00;
      sd_execute        <= 1'b0;
      sd_op_code        <= 1'b0;
      sd_sector_address <= '0;
    end else begin
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      req0_byte_stb <= byte_evt && !gnt;
      req1_byte_stb <= byte_evt && gnt;
      req0_done     <= finish_evt && !gnt;
      req1_done     <= finish_evt && gnt;
      req0_error    <= abort_evt && !gnt;
      req1_error    <= abort_evt && gnt;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt               <= arb_grant;
            sd_op_code        <= arb_grant ? req1_op : req0_op;
            sd_sector_address <= arb_grant ? req1_addr : req0_addr;
            byte_cnt          <= '0;
            timer             <= '0;
            req0_ready        <= !arb_grant;
            req1_ready        <= arb_grant;
            state             <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (abort_evt) begin
            sd_execute <= 1'b0;
            state      <= ST_ABORT;
          end else begin
            timer <= timer + 1'b1;
            // Execute is held at least one cycle before busy is honoured.
            if (sd_execute && sd_busy) begin
              sd_execute <= 1'b0;
              state      <= ST_XFER;
            end else begin
              sd_execute <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (byte_evt) begin
            byte_cnt <= cnt_next;
            timer    <= '0;
            if (sd_op_code == OP_READ) rdata <= sd_incoming_byte;
          end else begin
            timer <= timer + 1'b1;
          end
          if (abort_evt)       state <= ST_ABORT;
          else if (finish_evt) state <= ST_FINISH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Bench for sd_sector_arbiter: a sector-controller model plus scoreboard queues
// for handshake events and byte strobes, checked as the DUT produces them.
module tb_sd_sector_arbiter;
  import sd_pkg::*;

  localparam int SB = 512;
  localparam int TO = 16;

  localparam int EV_RDY = 16;
  localparam int EV_DONE = 32;
  localparam int EV_ERR = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req0_op, req1_valid, req1_op;
  logic [25:0] req0_addr, req1_addr;
  logic [7:0]  req0_wdata, req1_wdata;
  logic        req0_ready, req0_byte_stb, req0_done, req0_error;
  logic        req1_ready, req1_byte_stb, req1_done, req1_error;
  logic [7:0]  rdata;
  logic        sd_execute, sd_op_code;
  logic [25:0] sd_sector_address;
  logic [7:0]  sd_outgoing_byte, sd_incoming_byte;
  logic        sd_finished_byte, sd_finished_sector, sd_busy;

  int total = 0;
  int bad = 0;
  int ev_q[$];
  int rd_q[$];
  int mon_e;
  int mon_obs;

  sd_sector_arbiter #(.SECTOR_BYTES(SB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_byte_stb(req0_byte_stb), .req0_done(req0_done), .req0_error(req0_error),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_byte_stb(req1_byte_stb), .req1_done(req1_done), .req1_error(req1_error),
    .rdata(rdata), .sd_execute(sd_execute), .sd_op_code(sd_op_code),
    .sd_sector_address(sd_sector_address), .sd_outgoing_byte(sd_outgoing_byte),
    .sd_incoming_byte(sd_incoming_byte), .sd_finished_byte(sd_finished_byte),
    .sd_finished_sector(sd_finished_sector), .sd_busy(sd_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [51:0] outs();
    return {req0_ready, req0_byte_stb, req0_done, req0_error,
            req1_ready, req1_byte_stb, req1_done, req1_error,
            rdata, sd_execute, sd_op_code, sd_sector_address, sd_outgoing_byte};
  endfunction

  task automatic take_ev(input string tag, input int code);
    if (ev_q.size() == 0) chk({tag, "_unexpected"}, code, 0);
    else chk(tag, code, ev_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (req0_ready) take_ev("ready", EV_RDY + 0);
    if (req1_ready) take_ev("ready", EV_RDY + 1);
    if (req0_done)  take_ev("done", EV_DONE + 0);
    if (req1_done)  take_ev("done", EV_DONE + 1);
    if (req0_error) take_ev("error", EV_ERR + 0);
    if (req1_error) take_ev("error", EV_ERR + 1);
    if (req0_byte_stb || req1_byte_stb) begin
      chk("stb_both_ports", req0_byte_stb & req1_byte_stb, 0);
      if (rd_q.size() == 0) begin
        chk("stb_unexpected", {req1_byte_stb, req0_byte_stb}, 0);
      end else begin
        mon_e = rd_q.pop_front();
        mon_obs = (req1_byte_stb ? 512 : 0) + (mon_e[8] ? 256 + int'(rdata) : 0);
        chk("byte_stb", mon_obs, mon_e);
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req0_op = 0; req0_addr = '0; req0_wdata = 0;
    req1_valid = 0; req1_op = 0; req1_addr = '0; req1_wdata = 0;
    sd_incoming_byte = 0; sd_finished_byte = 0; sd_finished_sector = 0; sd_busy = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    adv();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 50) begin
      adv();
      n++;
    end
    chk("ready_seen", req0_ready | req1_ready, 1);
  endtask

  task automatic issue(input int port, input logic op, input logic [25:0] addr);
    if (port == 0) begin req0_op = op; req0_addr = addr; req0_valid = 1; end
    else begin req1_op = op; req1_addr = addr; req1_valid = 1; end
    adv();
    wait_ready();
    if (port == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // mode: 0 sector strobe after last byte, 1 sector with last byte,
  // 2 leave transfer open, 3 stall and time the error, 4 one extra byte
  task automatic serve(input int port, input logic op, input logic [25:0] addr,
                       input int nbytes, input int mode, input int seed);
    int n;
    logic [7:0] b;
    n = 0;
    while (!sd_execute && n < 40) begin
      adv();
      n++;
    end
    chk("execute", sd_execute, 1);
    chk("op_code", sd_op_code, op);
    chk("sector_addr", sd_sector_address, addr);
    sd_busy = 1;
    adv();
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((i + seed) & 255);
      if (op == OP_READ) begin
        sd_incoming_byte = b;
        rd_q.push_back(port * 512 + 256 + int'(b));
      end else begin
        chk("outgoing_byte", sd_outgoing_byte, (i + 1) & 255);
        rd_q.push_back(port * 512);
      end
      sd_finished_byte = 1;
      if (mode == 1 && i == nbytes - 1) sd_finished_sector = 1;
      adv();
      sd_finished_byte = 0;
      sd_finished_sector = 0;
      if (op == OP_WRITE) begin
        if (port == 0) req0_wdata = req0_wdata + 8'd1;
        else req1_wdata = req1_wdata + 8'd1;
      end
      adv();
    end
    case (mode)
      0: begin
        sd_finished_sector = 1;
        adv();
        sd_finished_sector = 0;
        adv();
      end
      3: begin
        n = 1;
        while (!(req0_error || req1_error) && n < 100) begin
          adv();
          n++;
        end
        chk("xfer_timeout_cycles", n, TO);
        adv();
      end
      4: begin
        sd_finished_byte = 1;
        adv();
        sd_finished_byte = 0;
        adv();
      end
      default: ;
    endcase
    if (mode != 2) sd_busy = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    apply_reset();
    chk("reset_outputs", outs(), 0);

    // single READ, port 0, bytes 00..FF twice
    ev_q.push_back(EV_RDY + 0); ev_q.push_back(EV_DONE + 0);
    issue(0, OP_READ, 26'h000123);
    serve(0, OP_READ, 26'h000123, SB, 0, 0);
    repeat (2) adv();

    // both valid at once after reset: alternate 0,1,0,1
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      ev_q.push_back(EV_RDY + (k % 2)); ev_q.push_back(EV_DONE + (k % 2));
    end
    req0_op = OP_READ; req0_addr = 26'h0000A0;
    req1_op = OP_READ; req1_addr = 26'h1000B1;
    req0_valid = 1; req1_valid = 1;
    adv();
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
      serve(k % 2, OP_READ, (k % 2 == 0) ? 26'h0000A0 : 26'h1000B1, SB, (k == 1) ? 1 : 0, k * 37 + 3);
    end
    repeat (2) adv();

    // WRITE from port 1 with incrementing wdata
    req1_wdata = 8'h01;
    ev_q.push_back(EV_RDY + 1); ev_q.push_back(EV_DONE + 1);
    issue(1, OP_WRITE, 26'h2ABCDE);
    serve(1, OP_WRITE, 26'h2ABCDE, SB, 0, 0);
    repeat (2) adv();

    // short sector: sector strobe after 300 bytes
    ev_q.push_back(EV_RDY + 0); ev_q.push_back(EV_ERR + 0);
    issue(0, OP_READ, 26'h000300);
    serve(0, OP_READ, 26'h000300, 300, 0, 11);
    repeat (2) adv();

    // 513th byte strobe
    ev_q.push_back(EV_RDY + 1); ev_q.push_back(EV_ERR + 1);
    issue(1, OP_READ, 26'h000513);
    serve(1, OP_READ, 26'h000513, SB, 4, 21);
    repeat (2) adv();

    // stall in XFER after 5 bytes
    ev_q.push_back(EV_RDY + 0); ev_q.push_back(EV_ERR + 0);
    issue(0, OP_READ, 26'h000055);
    serve(0, OP_READ, 26'h000055, 5, 3, 9);
    repeat (2) adv();

    // stall in LAUNCH: busy never rises
    ev_q.push_back(EV_RDY + 1); ev_q.push_back(EV_ERR + 1);
    issue(1, OP_WRITE, 26'h0000C7);
    n = 0;
    while (!(req0_error || req1_error) && n < 100) begin
      adv();
      n++;
    end
    chk("launch_timeout_cycles", n, TO);
    repeat (2) adv();

    // reset at byte 200 of a READ
    ev_q.push_back(EV_RDY + 0);
    issue(0, OP_READ, 26'h0000FE);
    serve(0, OP_READ, 26'h0000FE, 200, 2, 77);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs(), 0);
    sd_busy = 0;
    repeat (2) adv();
    chk("held_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    adv();

    ev_q.push_back(EV_RDY + 1); ev_q.push_back(EV_DONE + 1);
    issue(1, OP_READ, 26'h3FFFFF);
    serve(1, OP_READ, 26'h3FFFFF, SB, 0, 200);
    repeat (4) adv();

    chk("events_left", ev_q.size(), 0);
    chk("bytes_left", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
